// File: rtl/twos_serializer.sv
// ---------------------------------------------------------------------------
// twos_serializer
//
// Parallel-to-serial front end for a bit-serial two's-complement stage.
// Words arrive over a valid/ready handshake and leave LSB first, one bit per
// t_clk. ser_first marks the LSB cycle (drives the complementer's word-start
// input) and ser_last marks the MSB cycle (for the downstream deserializer).
//
// Parameters
//   WIDTH  word length in bits, 2..64
//   GAP    idle cycles forced after each word's MSB, 0..15
//
// Optional feature macro: SER_SKID_EN
//   Undefined (default): din_ready is high only in IDLE.
//   Defined: adds a one-word skid register, so din_ready means "skid empty"
//   and a pending word starts immediately after the previous MSB (+GAP).
//
// Ports
//   t_clk      in   1      clock, all state changes on its rising edge
//   r_n        in   1      asynchronous active-low reset
//   din        in   WIDTH  parallel word to serialize
//   din_valid  in   1      din holds a word
//   din_ready  out  1      block can take din this cycle (registered)
//   ser_bit    out  1      serial data, LSB first
//   ser_first  out  1      high on the LSB cycle only
//   ser_last   out  1      high on the MSB cycle only
//   ser_valid  out  1      ser_bit carries a word bit this cycle
//   busy       out  1      state != IDLE, or the skid register is full
// ---------------------------------------------------------------------------
module twos_serializer #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             t_clk,
    input  logic             r_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_bit,
    output logic             ser_first,
    output logic             ser_last,
    output logic             ser_valid,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         gap_q, gap_d;
    logic               din_ready_q, din_ready_d;
    logic               ser_first_q, ser_first_d;
    logic               ser_last_q, ser_last_d;
    logic               ser_valid_q, ser_valid_d;
    logic               busy_q, busy_d;
    logic               accept;
    logic               shifter_free;

`ifdef SER_SKID_EN
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic               skid_full_q, skid_full_d;
`endif

    // Next-state logic. shifter_free flags the edge on which the shifter can
    // take a new word: sitting in IDLE, finishing the MSB with no gap, or
    // finishing the last gap cycle. The shift register is zero-filled, so it
    // is already all zeros once the MSB has gone out and ser_bit reads 0 in
    // GAP and IDLE without extra gating.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        gap_d        = gap_q;
        shifter_free = 1'b0;
        accept       = din_valid && din_ready_q;
`ifdef SER_SKID_EN
        skid_d       = skid_q;
        skid_full_d  = skid_full_q;
`endif

        case (state_q)
            S_IDLE: begin
                shifter_free = 1'b1;
            end
            S_SHIFT: begin
                shift_d = shift_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (GAP > 0) begin
                        state_d = S_GAP;
                        gap_d   = 4'd0;
                    end else begin
                        state_d      = S_IDLE;
                        shifter_free = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d      = S_IDLE;
                    gap_d        = 4'd0;
                    shifter_free = 1'b1;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef SER_SKID_EN
        // A waiting skid word always wins the shifter; a word accepted on the
        // same edge takes its place in the skid. With nothing pending, a new
        // word goes straight to the shifter when it is free, else to the skid.
        if (shifter_free && skid_full_q) begin
            shift_d     = skid_q;
            state_d     = S_SHIFT;
            cnt_d       = '0;
            skid_full_d = 1'b0;
            if (accept) begin
                skid_d      = din;
                skid_full_d = 1'b1;
            end
        end else if (shifter_free && accept) begin
            shift_d = din;
            state_d = S_SHIFT;
            cnt_d   = '0;
        end else if (accept) begin
            skid_d      = din;
            skid_full_d = 1'b1;
        end
        din_ready_d = !skid_full_d;
        busy_d      = (state_d != S_IDLE) || skid_full_d;
`else
        if (shifter_free && accept) begin
            shift_d = din;
            state_d = S_SHIFT;
            cnt_d   = '0;
        end
        din_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
`endif

        // Output flags are registered from the next state so they line up
        // with the shift register contents they describe.
        ser_valid_d = (state_d == S_SHIFT);
        ser_first_d = (state_d == S_SHIFT) && (cnt_d == '0);
        ser_last_d  = (state_d == S_SHIFT) && (cnt_d == CNT_LAST);
    end

    // State and output registers. Reset abandons any word in flight and
    // holds din_ready low until the first edge after r_n releases.
    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            gap_q       <= 4'd0;
            din_ready_q <= 1'b0;
            ser_first_q <= 1'b0;
            ser_last_q  <= 1'b0;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SER_SKID_EN
            skid_q      <= '0;
            skid_full_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            din_ready_q <= din_ready_d;
            ser_first_q <= ser_first_d;
            ser_last_q  <= ser_last_d;
            ser_valid_q <= ser_valid_d;
            busy_q      <= busy_d;
`ifdef SER_SKID_EN
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
`endif
        end
    end

    assign din_ready = din_ready_q;
    assign ser_bit   = shift_q[0];
    assign ser_first = ser_first_q;
    assign ser_last  = ser_last_q;
    assign ser_valid = ser_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_twos_serializer.sv
// ---------------------------------------------------------------------------
// tb_twos_serializer
//
// Directed bench for twos_serializer. Two instances share clock and reset:
// dut0 (WIDTH=8, GAP=0) and dut3 (WIDTH=8, GAP=3). Expected values are hand
// derived; a tiny serial two's-complement model turns the collected bit
// stream into the result a downstream complementer would produce.
// ---------------------------------------------------------------------------
module tb_twos_serializer;

    localparam int W = 8;
`ifdef SER_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic       t_clk = 1'b0;
    logic       r_n   = 1'b1;
    logic [7:0] din0, din3;
    logic       vld0, vld3;
    logic       rdy0, bit0, first0, last0, val0, busy0;
    logic       rdy3, bit3, first3, last3, val3, busy3;

    int compared   = 0;
    int mismatched = 0;

    // Free-running 100 MHz style clock.
    always #5 t_clk = ~t_clk;

    twos_serializer #(.WIDTH(W), .GAP(0)) dut0 (
        .t_clk(t_clk), .r_n(r_n), .din(din0), .din_valid(vld0),
        .din_ready(rdy0), .ser_bit(bit0), .ser_first(first0),
        .ser_last(last0), .ser_valid(val0), .busy(busy0)
    );

    twos_serializer #(.WIDTH(W), .GAP(3)) dut3 (
        .t_clk(t_clk), .r_n(r_n), .din(din3), .din_valid(vld3),
        .din_ready(rdy3), .ser_bit(bit3), .ser_first(first3),
        .ser_last(last3), .ser_valid(val3), .busy(busy3)
    );

    // One comparison: counts it, and reports tag/observed/expected on a miss.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, away from the sampling edge.
    task automatic stepClk;
        @(posedge t_clk);
        #1;
    endtask

    // Serial two's complement: copy bits up to and including the first 1,
    // invert everything after it.
    function automatic logic [7:0] complementModel(input logic [7:0] bits);
        logic [7:0] res;
        logic       seen;
        seen = 1'b0;
        res  = '0;
        for (int i = 0; i < 8; i++) begin
            res[i] = bits[i] ^ seen;
            seen   = seen | bits[i];
        end
        return res;
    endfunction

    // Send one word into dut0 from IDLE and check every serial cycle.
    task automatic applyStimulus(input logic [7:0] w, input logic [7:0] expComp, input string tag);
        logic [7:0] got;
        got  = '0;
        din0 = w;
        vld0 = 1'b1;
        checkOutput({tag, " ready before accept"}, 64'(rdy0), 64'd1);
        stepClk();
        vld0 = 1'b0;
        din0 = ~w;
        for (int k = 0; k < W; k++) begin
            checkOutput($sformatf("%s valid c%0d", tag, k + 1), 64'(val0), 64'd1);
            checkOutput($sformatf("%s first c%0d", tag, k + 1), 64'(first0), 64'(k == 0));
            checkOutput($sformatf("%s last c%0d", tag, k + 1), 64'(last0), 64'(k == W - 1));
            checkOutput($sformatf("%s ready c%0d", tag, k + 1), 64'(rdy0), 64'(SKID));
            checkOutput($sformatf("%s busy c%0d", tag, k + 1), 64'(busy0), 64'd1);
            got[k] = bit0;
            stepClk();
        end
        checkOutput({tag, " word"}, 64'(got), 64'(w));
        checkOutput({tag, " complement"}, 64'(complementModel(got)), 64'(expComp));
        checkOutput({tag, " idle valid"}, 64'(val0), 64'd0);
        checkOutput({tag, " idle bit"}, 64'(bit0), 64'd0);
        checkOutput({tag, " idle first"}, 64'(first0), 64'd0);
        checkOutput({tag, " idle ready"}, 64'(rdy0), 64'd1);
        checkOutput({tag, " idle busy"}, 64'(busy0), 64'd0);
    endtask

    initial begin : main
        logic [7:0]  w2;
        logic [15:0] stream;
        int          lastCyc, secFirst, nFirst, nVal;

        din0 = '0; din3 = '0; vld0 = 1'b0; vld3 = 1'b0;

        // Reset asserted: every output reads 0 at once and stays 0.
        #1 r_n = 1'b0;
        #1;
        checkOutput("reset ready", 64'(rdy0), 64'd0);
        checkOutput("reset valid", 64'(val0), 64'd0);
        checkOutput("reset bit", 64'(bit0), 64'd0);
        checkOutput("reset busy", 64'(busy0), 64'd0);
        repeat (3) stepClk();
        checkOutput("reset held ready", 64'(rdy3), 64'd0);
        checkOutput("reset held first", 64'(first0), 64'd0);
        checkOutput("reset held last", 64'(last0), 64'd0);

        // Release: din_ready rises only on the first edge after r_n goes high.
        r_n = 1'b1;
        #2;
        checkOutput("release ready pre-edge", 64'(rdy0), 64'd0);
        stepClk();
        checkOutput("release ready dut0", 64'(rdy0), 64'd1);
        checkOutput("release ready dut3", 64'(rdy3), 64'd1);
        checkOutput("release busy", 64'(busy0), 64'd0);

        // Single words through the GAP=0 instance.
        applyStimulus(8'h06, 8'hFA, "w06");
        applyStimulus(8'h80, 8'h80, "w80");
        applyStimulus(8'h00, 8'h00, "w00");
        applyStimulus(8'hA5, 8'h5B, "wA5");

        // Reset on cycle 4 of a word: outputs clear without a clock edge.
        din0 = 8'hFF;
        vld0 = 1'b1;
        stepClk();
        vld0 = 1'b0;
        repeat (3) stepClk();
        checkOutput("midrst pre valid", 64'(val0), 64'd1);
        checkOutput("midrst pre bit", 64'(bit0), 64'd1);
        r_n = 1'b0;
        #1;
        checkOutput("midrst valid", 64'(val0), 64'd0);
        checkOutput("midrst bit", 64'(bit0), 64'd0);
        checkOutput("midrst first", 64'(first0), 64'd0);
        checkOutput("midrst last", 64'(last0), 64'd0);
        checkOutput("midrst ready", 64'(rdy0), 64'd0);
        checkOutput("midrst busy", 64'(busy0), 64'd0);
        stepClk();
        r_n = 1'b1;
        #2;
        checkOutput("midrst release ready", 64'(rdy0), 64'd0);
        stepClk();
        checkOutput("midrst ready after edge", 64'(rdy0), 64'd1);
        checkOutput("midrst no partial bits", 64'(val0), 64'd0);
        applyStimulus(8'h06, 8'hFA, "post-reset w06");

        // GAP=3: two words offered back-to-back with din_valid held high and
        // din changed mid-word.
        din3 = 8'h3C;
        vld3 = 1'b1;
        stepClk();
        din3 = 8'hC3;
        lastCyc = -1; secFirst = -1; nFirst = 0; w2 = '0;
        for (int c = 1; c <= 24; c++) begin
            if (c <= 12)
                checkOutput($sformatf("gap3 ready c%0d", c), 64'(rdy3),
                            64'((c == 12) || (SKID && c == 1)));
            if (c >= 9 && c <= 11)
                checkOutput($sformatf("gap3 gap valid c%0d", c), 64'(val3), 64'd0);
            if (c <= 8)
                checkOutput($sformatf("gap3 first word bit c%0d", c), 64'(bit3),
                            64'(((8'h3C) >> (c - 1)) & 8'h01));
            if (last3 && lastCyc < 0) lastCyc = c;
            if (first3) begin
                nFirst++;
                if (nFirst == 2) secFirst = c;
            end
            if (secFirst > 0 && val3 && (c - secFirst) < 8) w2[c - secFirst] = bit3;
            if (c == (SKID ? 2 : 13)) vld3 = 1'b0;
            stepClk();
        end
        checkOutput("gap3 first MSB cycle", 64'(lastCyc), 64'd8);
        checkOutput("gap3 second LSB cycle", 64'(secFirst), SKID ? 64'd12 : 64'd13);
        checkOutput("gap3 MSB to LSB distance", 64'(secFirst - lastCyc), SKID ? 64'd4 : 64'd5);
        checkOutput("gap3 second word", 64'(w2), 64'hC3);
        checkOutput("gap3 word count", 64'(nFirst), 64'd2);

        // GAP=0: 8'h01 then 8'hFF; with the skid they stream back-to-back.
        din0 = 8'h01;
        vld0 = 1'b1;
        stepClk();
        din0 = 8'hFF;
        stream = '0;
        nVal = 0;
        for (int c = 1; c <= 19; c++) begin
            checkOutput($sformatf("b2b valid c%0d", c), 64'(val0),
                        SKID ? 64'(c <= 16) : 64'(c <= 8 || (c >= 10 && c <= 17)));
            checkOutput($sformatf("b2b first c%0d", c), 64'(first0),
                        64'(c == 1 || c == (SKID ? 9 : 10)));
            if (c <= 10)
                checkOutput($sformatf("b2b ready c%0d", c), 64'(rdy0),
                            SKID ? 64'(c == 1 || c >= 9) : 64'(c == 9));
            if (val0 && nVal < 16) begin
                stream[nVal] = bit0;
                nVal++;
            end
            if (c == (SKID ? 2 : 10)) vld0 = 1'b0;
            stepClk();
        end
        checkOutput("b2b stream", 64'(stream), 64'hFF01);
        checkOutput("b2b valid count", 64'(nVal), 64'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
